cordic_output_stage: RTL

- Final stage of the pipelined CORDIC rotator. Sits directly downstream of the last shift-accumulate iteration stage.
- Consumes the final x/y/z words and applies CORDIC gain compensation and quadrant-correction negation.
- Re-aligns the per-sample valid and quadrant tag, which the iteration stages do not carry, with a delay line.
- Buffers results in a small FIFO so a back-pressuring consumer can be served from a non-stallable pipeline.

---
 rtl/cordic_pkg.sv | 26 ++
 rtl/cordic_output_stage_if.sv | 29 ++
 rtl/cordic_out_fifo.sv | 58 +++++
 rtl/cordic_output_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC output stage.
// Gain compensation is built only when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned FRAC_W         = 30;
  localparam logic [WORD_W-1:0] CORDIC_K = 32'h26DD3B6A; // 0.6072529350 in Q2.30
  localparam int unsigned PIPE_DEPTH_DEF = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t x;
    word_t y;
    word_t z;
  } result_t;

  // Two's-complement negation that maps the most negative value to the most positive.
  function automatic word_t sat_neg(input word_t v);
    if (v == {1'b1, {(WORD_W-1){1'b0}}}) begin
      return {1'b0, {(WORD_W-1){1'b1}}};
    end
    return ~v + word_t'(1);
  endfunction

endpackage

// File: rtl/cordic_output_stage_if.sv
// Sample input / buffered result bus of the CORDIC output stage.
interface cordic_output_stage_if;
  import cordic_pkg::*;

  logic  in_valid;
  logic  quad_neg_in;
  word_t x;
  word_t y;
  word_t z;
  logic  out_ready;
  logic  out_valid;
  word_t x_out;
  word_t y_out;
  word_t z_out;
  logic  overflow;

  // The output stage itself.
  modport slave (
    input  in_valid, quad_neg_in, x, y, z, out_ready,
    output out_valid, x_out, y_out, z_out, overflow
  );

  // Upstream pipeline plus downstream consumer.
  modport master (
    output in_valid, quad_neg_in, x, y, z, out_ready,
    input  out_valid, x_out, y_out, z_out, overflow
  );

endinterface

// File: rtl/cordic_out_fifo.sv
// First-word fall-through result FIFO. DEPTH must be a power of two >= 2.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cordic_out_fifo
  import cordic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  result_t wdata_i,
  input  logic    pop_i,
  output result_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok;
  logic        pop_ok;
  result_t     mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are only observable through valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cordic_output_stage.sv
// Final CORDIC stage: re-aligns valid/quadrant tag with a delay line,
// applies gain compensation (only with CORDIC_GAIN_COMP_EN) and quadrant
// negation, then buffers results in a FWFT FIFO with sticky overflow.
module cordic_output_stage
  import cordic_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cordic_output_stage_if.slave bus
);

  localparam int unsigned PW = 2 * WORD_W;

  logic [PIPE_DEPTH-1:0] dv_q, dv_d;
  logic [PIPE_DEPTH-1:0] dn_q, dn_d;
  logic                  tap_valid;
  logic                  tap_neg;

  logic                  s1_valid_q;
  logic                  s1_neg_q;
  word_t                 s1_z_q;
`ifdef CORDIC_GAIN_COMP_EN
  logic signed [PW-1:0]  s1_x_q, s1_x_d;
  logic signed [PW-1:0]  s1_y_q, s1_y_d;
  logic signed [PW-1:0]  sh_x, sh_y;
  logic                  unused_sh_hi;
`else
  word_t                 s1_x_q, s1_x_d;
  word_t                 s1_y_q, s1_y_d;
`endif

  word_t                 s2_x, s2_y;
  logic                  s2_valid_q;
  result_t               s2_res_q, s2_res_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  result_t               fifo_head;
  result_t               last_q;
  result_t               out_word;
  logic                  overflow_q, overflow_d;

  // Tag/valid delay line matching the iteration stages.
  always_comb begin
    dv_d    = dv_q;
    dn_d    = dn_q;
    dv_d[0] = bus.in_valid;
    dn_d[0] = bus.quad_neg_in;
    for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
      dv_d[i] = dv_q[i-1];
      dn_d[i] = dn_q[i-1];
    end
  end

  assign tap_valid = dv_q[PIPE_DEPTH-1];
  assign tap_neg   = dn_q[PIPE_DEPTH-1];

  // Delay-line registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q <= '0;
      dn_q <= '0;
    end else begin
      dv_q <= dv_d;
      dn_q <= dn_d;
    end
  end

  // S1 operands: full-width gain products, or the raw words when compensation is off.
  always_comb begin
    s1_x_d = '0;
    s1_y_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
    s1_x_d = PW'(signed'(bus.x)) * PW'(signed'(CORDIC_K));
    s1_y_d = PW'(signed'(bus.y)) * PW'(signed'(CORDIC_K));
`else
    s1_x_d = bus.x;
    s1_y_d = bus.y;
`endif
  end

  // S1 registers, loaded in the cycle the delayed valid marks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_z_q     <= '0;
    end else begin
      s1_valid_q <= tap_valid;
      if (tap_valid) begin
        s1_neg_q <= tap_neg;
        s1_x_q   <= s1_x_d;
        s1_y_q   <= s1_y_d;
        s1_z_q   <= bus.z;
      end
    end
  end

  // S2: rescale products back to Q2.30 (floor) and apply quadrant negation.
  always_comb begin
    s2_res_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
    sh_x = s1_x_q >>> FRAC_W;
    sh_y = s1_y_q >>> FRAC_W;
    s2_x = sh_x[WORD_W-1:0];
    s2_y = sh_y[WORD_W-1:0];
`else
    s2_x = s1_x_q;
    s2_y = s1_y_q;
`endif
    s2_res_d.x = s1_neg_q ? sat_neg(s2_x) : s2_x;
    s2_res_d.y = s1_neg_q ? sat_neg(s2_y) : s2_y;
    s2_res_d.z = s1_z_q;
  end

`ifdef CORDIC_GAIN_COMP_EN
  // Upper product bits fall outside the Q2.30 result word by construction.
  assign unused_sh_hi = ^{sh_x[PW-1:WORD_W], sh_y[PW-1:WORD_W]};
`endif

  // S2 registers feeding the FIFO push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_res_q <= s2_res_d;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign fifo_pop   = ~fifo_empty & bus.out_ready;
  assign fifo_push  = s2_valid_q & (~fifo_full | fifo_pop);
  assign overflow_d = overflow_q | (s2_valid_q & fifo_full & ~fifo_pop);

  cordic_out_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .wdata_i(s2_res_q),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Sticky overflow flag and last-popped word held while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      overflow_q <= overflow_d;
      if (fifo_pop) last_q <= fifo_head;
    end
  end

  assign out_word      = fifo_empty ? last_q : fifo_head;
  assign bus.out_valid = ~fifo_empty;
  assign bus.x_out     = out_word.x;
  assign bus.y_out     = out_word.y;
  assign bus.z_out     = out_word.z;
  assign bus.overflow  = overflow_q;

endmodule
